// File: rtl/pdm_pkg.sv
// Shared constants and state encoding for the PDM panel driver.
// Defaults size a 4x8 panel with 8-bit pixel intensity.
package pdm_pkg;

   localparam int DEF_ROWS = 4;
   localparam int DEF_COLS = 8;
   localparam int DEF_DW   = 8;
   localparam int NPIX     = DEF_ROWS * DEF_COLS;

   typedef enum logic [1:0] {
      IDLE,
      SHIFT,
      LATCH
   } pdm_state_t;

endpackage

// File: rtl/panel_shift_out.sv
// Serialises one row of PDM bits into the panel column shift register,
// then latches it and selects the row. Requests one bit per column.
module panel_shift_out
   import pdm_pkg::*;
#(
   parameter int ROWS = DEF_ROWS,
   parameter int COLS = DEF_COLS
) (
   input  logic                    fast_clk,
   input  logic                    reset,
   input  logic                    start,
   input  logic [$clog2(ROWS)-1:0] row,
   output logic                    accept,
   output logic                    bit_req,
   output logic [$clog2(COLS)-1:0] bit_col,
   input  logic                    bit_val,
   output logic                    panel_data,
   output logic                    panel_clk,
   output logic                    panel_latch,
   output logic                    panel_oe,
   output logic [$clog2(ROWS)-1:0] panel_row,
   output logic                    busy
);

   localparam int CB = $clog2(COLS);

   pdm_state_t    state;
   logic [CB-1:0] col;
   logic          phase;

   assign accept = (state != SHIFT);

   // Bit for the column about to enter phase 0 is fetched one edge early.
   always_comb begin
      bit_req = 1'b0;
      bit_col = col;
      unique case (state)
         IDLE: begin
            if (start) begin
               bit_req = 1'b1;
               bit_col = CB'(COLS - 1);
            end
         end
         SHIFT: begin
            if (phase && col != '0) begin
               bit_req = 1'b1;
               bit_col = col - 1'b1;
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge fast_clk) begin
      if (reset) begin
         state       <= IDLE;
         col         <= '0;
         phase       <= 1'b0;
         panel_data  <= 1'b0;
         panel_clk   <= 1'b0;
         panel_latch <= 1'b0;
         panel_oe    <= 1'b0;
         panel_row   <= '0;
         busy        <= 1'b0;
      end else begin
         unique case (state)
            IDLE: begin
               if (start) begin
                  state      <= SHIFT;
                  col        <= CB'(COLS - 1);
                  phase      <= 1'b0;
                  panel_data <= bit_val;
                  panel_clk  <= 1'b0;
                  busy       <= 1'b1;
               end
            end
            SHIFT: begin
               if (!phase) begin
                  phase     <= 1'b1;
                  panel_clk <= 1'b1;
               end else if (col != '0) begin
                  col        <= col - 1'b1;
                  phase      <= 1'b0;
                  panel_clk  <= 1'b0;
                  panel_data <= bit_val;
               end else begin
                  state       <= LATCH;
                  panel_clk   <= 1'b0;
                  panel_latch <= 1'b1;
                  panel_oe    <= 1'b0;
                  panel_row   <= row;
               end
            end
            LATCH: begin
               state       <= IDLE;
               panel_latch <= 1'b0;
               panel_oe    <= 1'b1;
               busy        <= 1'b0;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: rtl/pdm_panel_driver.sv
// Row capture, double buffering and per-pixel sigma-delta accumulators
// feeding the serial panel shifter.
module pdm_panel_driver
   import pdm_pkg::*;
#(
   parameter int ROWS = DEF_ROWS,
   parameter int COLS = DEF_COLS,
   parameter int DW   = DEF_DW
) (
   input  logic                    fast_clk,
   input  logic                    reset,
   input  logic                    pix_valid,
   input  logic [$clog2(COLS)-1:0] pix_col,
   input  logic [$clog2(ROWS)-1:0] pix_row,
   input  logic [DW-1:0]           pix_data,
   input  logic                    row_done,
   output logic                    panel_data,
   output logic                    panel_clk,
   output logic                    panel_latch,
   output logic                    panel_oe,
   output logic [$clog2(ROWS)-1:0] panel_row,
   output logic                    busy,
   output logic                    overrun
);

   localparam int RB = $clog2(ROWS);
   localparam int CB = $clog2(COLS);
   localparam int NP = ROWS * COLS;

   logic [DW-1:0]    back    [COLS];
   logic [DW-1:0]    back_nx [COLS];
   logic [DW-1:0]    front   [COLS];
   logic [DW-1:0]    snap    [COLS];
   logic [DW-1:0]    acc     [NP];
   logic [RB-1:0]    cur_row;
   logic [RB-1:0]    pend_row;
   logic             pending;
   logic             go;
   logic             accept;
   logic             launch;
   logic             bit_req;
   logic [CB-1:0]    bit_col;
   logic             bit_val;
   logic [RB+CB-1:0] acc_idx;
   logic [DW:0]      sum;

   // A write in the row_done cycle must be part of the copied row.
   always_comb begin
      for (int i = 0; i < COLS; i++) back_nx[i] = back[i];
      if (pix_valid) back_nx[pix_col] = pix_data;
   end

   assign acc_idx = {cur_row, bit_col};
   assign sum     = {1'b0, acc[acc_idx]} + {1'b0, front[bit_col]};
   assign bit_val = sum[DW];

   // Launching while the shifter latches leaves exactly one idle cycle.
   assign launch = accept & ~go;

   always_ff @(posedge fast_clk) begin
      if (reset) begin
         for (int i = 0; i < COLS; i++) begin
            back[i]  <= '0;
            front[i] <= '0;
            snap[i]  <= '0;
         end
         cur_row  <= '0;
         pend_row <= '0;
         pending  <= 1'b0;
         go       <= 1'b0;
         overrun  <= 1'b0;
      end else begin
         for (int i = 0; i < COLS; i++) back[i] <= back_nx[i];
         go      <= 1'b0;
         overrun <= 1'b0;
         if (launch && pending) begin
            front   <= snap;
            cur_row <= pend_row;
            go      <= 1'b1;
            pending <= row_done;
            if (row_done) begin
               snap     <= back_nx;
               pend_row <= pix_row;
            end
         end else if (launch && row_done) begin
            front   <= back_nx;
            cur_row <= pix_row;
            go      <= 1'b1;
         end else if (row_done) begin
            overrun  <= pending;
            pending  <= 1'b1;
            snap     <= back_nx;
            pend_row <= pix_row;
         end
      end
   end

   always_ff @(posedge fast_clk) begin
      if (reset) begin
         for (int i = 0; i < NP; i++) acc[i] <= '0;
      end else if (bit_req) begin
         acc[acc_idx] <= sum[DW-1:0];
      end
   end

   panel_shift_out #(
      .ROWS (ROWS),
      .COLS (COLS)
   ) u_shift (
      .fast_clk    (fast_clk),
      .reset       (reset),
      .start       (go),
      .row         (cur_row),
      .accept      (accept),
      .bit_req     (bit_req),
      .bit_col     (bit_col),
      .bit_val     (bit_val),
      .panel_data  (panel_data),
      .panel_clk   (panel_clk),
      .panel_latch (panel_latch),
      .panel_oe    (panel_oe),
      .panel_row   (panel_row),
      .busy        (busy)
   );

endmodule

// File: tb/tb_pdm_panel_driver.sv
// Scoreboard bench for pdm_panel_driver: shifted bits and latched rows
// are queued at stimulus time and checked by a monitor.
module tb_pdm_panel_driver;

   logic       fast_clk = 1'b0;
   logic       reset = 1'b1;
   logic       pix_valid = 1'b0;
   logic [2:0] pix_col = '0;
   logic [1:0] pix_row = '0;
   logic [7:0] pix_data = '0;
   logic       row_done = 1'b0;
   logic       panel_data;
   logic       panel_clk;
   logic       panel_latch;
   logic       panel_oe;
   logic [1:0] panel_row;
   logic       busy;
   logic       overrun;

   int   nvec = 0;
   int   nfail = 0;
   int   ovr_cnt = 0;
   logic clk_q = 1'b0;
   logic bit_q [$];
   int   row_q [$];

   pdm_panel_driver dut (
      .fast_clk    (fast_clk),
      .reset       (reset),
      .pix_valid   (pix_valid),
      .pix_col     (pix_col),
      .pix_row     (pix_row),
      .pix_data    (pix_data),
      .row_done    (row_done),
      .panel_data  (panel_data),
      .panel_clk   (panel_clk),
      .panel_latch (panel_latch),
      .panel_oe    (panel_oe),
      .panel_row   (panel_row),
      .busy        (busy),
      .overrun     (overrun)
   );

   always #5 fast_clk = ~fast_clk;

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   // Monitor: pop on each panel_clk rise and each latch.
   always @(negedge fast_clk) begin
      logic e;
      int   r;
      if (panel_clk && !clk_q) begin
         nvec++;
         if (bit_q.size() == 0) begin
            nfail++;
            $display("FAIL bit_unexpected: got %b, none queued", panel_data);
         end else begin
            e = bit_q.pop_front();
            if (panel_data !== e) begin
               nfail++;
               $display("FAIL bit: got %b expected %b", panel_data, e);
            end
         end
      end
      if (panel_latch) begin
         nvec++;
         if (row_q.size() == 0) begin
            nfail++;
            $display("FAIL row_unexpected: got %0d, none queued", panel_row);
         end else begin
            r = row_q.pop_front();
            if (panel_row !== 2'(r)) begin
               nfail++;
               $display("FAIL row: got %0d expected %0d", panel_row, r);
            end
         end
      end
      if (overrun) ovr_cnt++;
      clk_q = panel_clk;
   end

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      nvec++;
      if (act !== exp) begin
         nfail++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic set_pix(input int c, input int v);
      pix_valid = 1'b1;
      pix_col   = 3'(c);
      pix_data  = 8'(v);
      @(posedge fast_clk); #2;
      pix_valid = 1'b0;
   endtask

   task automatic load_all(input int v);
      for (int c = 0; c < 8; c++) set_pix(c, v);
   endtask

   task automatic push_disp(input logic [7:0] b, input int r);
      for (int c = 7; c >= 0; c--) bit_q.push_back(b[c]);
      row_q.push_back(r);
   endtask

   task automatic pulse_row(input int r);
      row_done = 1'b1;
      pix_row  = 2'(r);
      @(posedge fast_clk); #2;
      row_done = 1'b0;
   endtask

   task automatic wait_done();
      int n = 0;
      while (busy !== 1'b1 && n < 60) begin
         @(negedge fast_clk); n++;
      end
      while (busy !== 1'b0 && n < 60) begin
         @(negedge fast_clk); n++;
      end
      if (n >= 60) begin
         nfail++;
         $display("FAIL wait_done: busy got %b required 0", busy);
      end
      @(posedge fast_clk); #2;
   endtask

   task automatic chk_reset_outs(input string nm);
      chk(nm, {25'd0, panel_data, panel_clk, panel_latch, panel_oe,
               panel_row, busy, overrun}, 32'd0);
   endtask

   initial begin
      int t_bu, t_ck, t_la, t_bd;
      logic oe_la, oe_end;
      logic [7:0] b;

      repeat (3) @(posedge fast_clk);
      #2 reset = 1'b0;

      // Idle after reset: everything low, panel blank.
      for (int i = 0; i < 5; i++) begin
         @(negedge fast_clk);
         chk_reset_outs("idle_outs");
      end
      @(posedge fast_clk); #2;

      // Row 2 at 128: displays 0,1,0 with timing on the first.
      load_all(128);
      push_disp(8'h00, 2);
      pulse_row(2);
      t_bu = -1; t_ck = -1; t_la = -1; t_bd = -1;
      oe_la = 1'bx; oe_end = 1'bx;
      for (int j = 0; j < 24; j++) begin
         @(negedge fast_clk);
         if (t_bu < 0 && busy) t_bu = j;
         if (t_ck < 0 && panel_clk) t_ck = j;
         if (t_la < 0 && panel_latch) begin
            t_la = j; oe_la = panel_oe;
         end
         if (t_bu >= 0 && t_bd < 0 && !busy) begin
            t_bd = j; oe_end = panel_oe;
         end
      end
      chk("busy_rise", t_bu, 1);
      chk("clk_rise", t_ck, 2);
      chk("latch_at", t_la, 17);
      chk("busy_fall", t_bd, 18);
      chk("oe_in_latch", {31'd0, oe_la}, 0);
      chk("oe_after", {31'd0, oe_end}, 1);
      chk("panel_row", {30'd0, panel_row}, 2);
      @(posedge fast_clk); #2;
      push_disp(8'hff, 2);
      pulse_row(2);
      wait_done();
      push_disp(8'h00, 2);
      pulse_row(2);
      wait_done();

      // Fourth display would be all ones; reset after two shifted bits.
      bit_q.push_back(1'b1);
      bit_q.push_back(1'b1);
      pulse_row(2);
      repeat (4) @(posedge fast_clk);
      #2 reset = 1'b1;
      @(posedge fast_clk);
      @(posedge fast_clk); #2;
      reset = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge fast_clk);
         chk_reset_outs("reset_outs");
      end
      @(posedge fast_clk); #2;
      load_all(128);
      push_disp(8'h00, 2);
      pulse_row(2);
      wait_done();
      push_disp(8'hff, 2);
      pulse_row(2);
      wait_done();

      // Rows 1 then 3 arrive while row 0 is busy: row 3 wins.
      push_disp(8'h00, 0);
      push_disp(8'h00, 3);
      row_done = 1'b1;
      pix_row  = 2'd0;
      @(posedge fast_clk); #2;
      pix_row = 2'd1;
      @(posedge fast_clk); #2;
      pix_row = 2'd3;
      @(posedge fast_clk); #2;
      row_done = 1'b0;
      wait_done();
      wait_done();
      chk("overrun_cnt", ovr_cnt, 1);

      // Row 1 (never displayed): 64 in col 0, 255 in col 7.
      load_all(0);
      set_pix(0, 64);
      set_pix(7, 255);
      for (int d = 1; d <= 256; d++) begin
         b    = 8'h00;
         b[7] = (d != 1);
         b[0] = (d % 4 == 0);
         push_disp(b, 1);
         pulse_row(1);
         wait_done();
      end

      repeat (4) @(posedge fast_clk);
      chk("bits_left", bit_q.size(), 0);
      chk("rows_left", row_q.size(), 0);
      chk("overrun_final", ovr_cnt, 1);
      $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
      $finish;
   end

endmodule

// File: doc/pdm_panel_driver.md
# pdm_panel_driver

Consumer end of the SPRAM read stream. It captures one row of pixels as the read phase streams it out of SPRAM on `fast_clk`, and double-buffers the row. It then runs a first-order sigma-delta (PDM) step on every pixel and shifts the resulting on/off bits serially into the LED panel's column shift register, followed by latch and row select. Each pixel has its own accumulator, so brightness builds up across successive refreshes of its row.

## Interface
Parameters:
- `ROWS`, 4, panel rows; must be a power of 2; `RB = $clog2(ROWS)`.
- `COLS`, 8, panel columns; must be a power of 2; `CB = $clog2(COLS)`.
- `DW`, 8, pixel intensity width.

Ports:
- `fast_clk`  in  1  clock.
- `reset`  in  1  synchronous, active-high; clock `fast_clk`.
- `pix_valid`  in  1  `pix_data` is valid for column `pix_col` this cycle.
- `pix_col`  in  CB  column index of `pix_data`.
- `pix_row`  in  RB  row index; sampled only when `row_done` is high.
- `pix_data`  in  DW  pixel intensity.
- `row_done`  in  1  one-cycle pulse; the back buffer holds a complete row.
- `panel_data`  out  1  serial column bit.
- `panel_clk`  out  1  shift clock; panel samples on its rising edge.
- `panel_latch`  out  1  transfers the shift register to the column drivers.
- `panel_oe`  out  1  active-high output enable.
- `panel_row`  out  RB  row select for the displayed row.
- `busy`  out  1  shifter is not idle.
- `overrun`  out  1  one-cycle pulse when a pending row is replaced.

## Operation
- Back buffer: `COLS`×`DW` registers. When `pix_valid` is high, `back[pix_col]` <= `pix_data`.
- If `pix_valid` and `row_done` occur in the same cycle, the write lands in the back buffer before the copy to the front buffer.
- `row_done` with FSM in IDLE and no pending row:
  - front buffer <= back buffer (whole row, one cycle).
  - `cur_row` <= `pix_row`.
  - FSM -> SHIFT.
- `row_done` while `busy`:
  - pending <= 1; the pending row number and a snapshot of the back buffer are stored.
  - If pending is already 1, the snapshot is replaced (latest row wins) and `overrun` pulses.
- FSM states:
  - IDLE: exits to SHIFT on a pending row or on `row_done`.
  - SHIFT: handles column `c` from COLS-1 down to 0, two cycles per column.
    - Phase 0: `panel_clk`=0; `panel_data` = PDM bit of (`cur_row`, `c`).
    - Phase 1: `panel_clk`=1; `panel_data` is held.
  - LATCH: one cycle with `panel_latch`=1 and `panel_oe`=0. `panel_row` <= `cur_row`. Then IDLE with `panel_oe`=1.
- PDM step, performed in SHIFT phase 0 for pixel p = `front[c]`, with accumulator a = `acc[cur_row*COLS + c]` (DW bits):
  - s = a + p, computed in DW+1 bits.
  - Output bit = s[DW].
  - The accumulator takes s[DW-1:0].
- Accumulator array: `ROWS*COLS` entries × DW bits, all zero after reset. Each accumulator is updated exactly once per display of its row.
- p=0 never lights. p=2^DW−1 lights 2^DW−1 times in every 2^DW displays.
- Reset mid-SHIFT:
  - FSM -> IDLE; pending is cleared.
  - Accumulators and both buffers are cleared.
  - All outputs take their reset values on the next edge.

## Timing
- Reset values: `panel_data`=0, `panel_clk`=0, `panel_latch`=0, `panel_oe`=0 (blank until the first latch), `panel_row`=0, `busy`=0, `overrun`=0.
- All outputs are registered. There is no combinational path from inputs to outputs.
- `row_done` high at edge k:
  - Edge k+1: SHIFT begins with column COLS-1, phase 0; `busy`=1.
  - First `panel_clk` rise at edge k+2.
  - LATCH at edge k+1+2·COLS.
  - IDLE at edge k+2+2·COLS; `busy`=0.
- Total: 2·COLS+1 busy cycles per row. With COLS=8 that is 17 cycles.
- A pending row starts SHIFT on the edge after IDLE is entered. This gives one IDLE cycle with `panel_oe`=1 between rows.
- `panel_oe` is 0 only during LATCH, apart from the blank period after reset.
- `panel_data` is stable for the full phase-0 plus phase-1 window: setup of one cycle before the `panel_clk` rise, and hold until the next phase 0.

## Structure
- Package `pdm_pkg`:
  - Defaults for `ROWS`/`COLS`/`DW`.
  - FSM state enum: IDLE, SHIFT, LATCH.
  - Helper constant `NPIX = ROWS*COLS`.
- Sub-module `panel_shift_out` (one instance) contains:
  - The FSM.
  - The column/phase counter.
  - `panel_*` output registers.
  - It requests one PDM bit per column from the parent through a column-index / bit handshake.
- The parent contains the buffers, the pending logic and the accumulator array.

## Test plan
- Reset, then hold idle → all outputs 0; `panel_oe` stays 0; `busy`=0.
- Load row 2 with every pixel = 128, then pulse `row_done` three times, each after `busy` falls:
  - Displays 1 and 3: 8 shifted bits, all 0.
  - Display 2: 8 shifted bits, all 1.
  - `panel_row`=2 after the first LATCH.
- Pixel = 64 in column 0 and 255 in column 7, other columns 0:
  - Column 0 bit is 1 only on displays 4, 8, ….
  - Column 7 bit is 0 on display 1 and 1 on displays 2..256.
  - Other columns are always 0.
- `row_done` at edge k (COLS=8) → `busy` rises at k+1, first `panel_clk` rise at k+2, `panel_latch` at k+17, `busy` falls at k+18.
- Two `row_done` pulses for rows 1 and 3 during SHIFT → one `overrun` pulse; row 3 is displayed next and row 1 never latches.
- Assert `reset` mid-SHIFT → outputs return to reset values. Replaying the 128-pattern then starts again with bit 0, showing the accumulators were cleared.
